// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed, checksummed byte stream into
// little-endian 32-bit words and drives the instruction memory write port.
// The core is held in reset (cpu_hold) for the whole load.
//
// Byte handshake: a byte moves on a rising edge where byte_valid && byte_ready.
// The sender may hold byte_valid low for any number of cycles. The loader
// drops byte_ready in IDLE and WRITE, so a pending byte simply waits.
module imem_loader #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_WRITE,
      S_CHECK
   } state_t;

   localparam logic [8:0]        DEPTH_B = 9'(DEPTH);
   localparam logic [ADDR_W:0]   ONE_CNT = 1;
   localparam logic [ADDR_W-1:0] ONE_IDX = 1;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W:0]   count;     // number of words in the image (1..DEPTH)
   logic [ADDR_W-1:0] index;     // word currently being assembled
   logic [1:0]        lane;      // byte position within the word
   logic [7:0]        sum;       // running checksum of data bytes
   logic [23:0]       word_buf;  // lanes 0..2; lane 3 is taken straight from the stream
   logic              xfer;
   logic              len_ok;
   logic              last_word;

   assign xfer      = byte_valid && byte_ready;
   assign len_ok    = (byte_data != 8'd0) && ({1'b0, byte_data} <= DEPTH_B);
   assign last_word = ({1'b0, index} == (count - ONE_CNT));

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic and Moore handshake/status outputs.
   always_comb begin
      state_nxt  = state;
      byte_ready = 1'b0;
      busy       = 1'b0;
      cpu_hold   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_LEN;
         end
         S_LEN: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            cpu_hold   = 1'b1;
            if (xfer) state_nxt = len_ok ? S_DATA : S_IDLE;
         end
         S_DATA: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            cpu_hold   = 1'b1;
            if (xfer && lane == 2'd3) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            busy     = 1'b1;
            cpu_hold = 1'b1;
            state_nxt = last_word ? S_CHECK : S_DATA;
         end
         S_CHECK: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            cpu_hold   = 1'b1;
            if (xfer) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: length capture, word assembly, checksum, write port and status flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         index    <= '0;
         lane     <= '0;
         sum      <= '0;
         word_buf <= '0;
         we       <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         we   <= 1'b0;
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  error <= 1'b0;
                  index <= '0;
                  lane  <= '0;
                  sum   <= '0;
               end
            end
            S_LEN: begin
               if (xfer) begin
                  if (len_ok) count <= (ADDR_W+1)'(byte_data);
                  else        error <= 1'b1;
               end
            end
            S_DATA: begin
               if (xfer) begin
                  lane <= lane + 2'd1;
                  sum  <= sum + byte_data;
                  case (lane)
                     2'd0: word_buf[7:0]   <= byte_data;
                     2'd1: word_buf[15:8]  <= byte_data;
                     2'd2: word_buf[23:16] <= byte_data;
                     default: begin
                        // Fourth byte completes the word: register the write
                        // so it is presented during the WRITE cycle.
                        we    <= 1'b1;
                        waddr <= index;
                        wdata <= {byte_data, word_buf};
                     end
                  endcase
               end
            end
            S_WRITE: begin
               if (!last_word) index <= index + ONE_IDX;
            end
            S_CHECK: begin
               if (xfer) begin
                  if (byte_data == sum) done  <= 1'b1;
                  else                  error <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: drives length/data/checksum byte images and
// compares the write-port traffic and completion status against a
// reference built from the image format rules.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int failures = 0;

  logic [37:0] exp_wr_q[$];   // {waddr, wdata}
  logic [0:0]  exp_ev_q[$];   // 1 = done expected, 0 = error expected
  logic [31:0] img [0:63];
  logic        error_q = 1'b0;

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .cpu_hold(cpu_hold),
    .busy(busy),
    .done(done),
    .error(error)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout actual=ready_low expected=ready_high");
      byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_wr_q.size() != 0 || exp_ev_q.size() != 0) && t < 30) begin
      @(posedge clk);
      t++;
    end
    chk(name, 64'(exp_wr_q.size() + exp_ev_q.size()), 64'd0);
  endtask

  // Load an image of n words from img[]. The checksum is either the correct
  // byte sum plus chk_delta, or chk_val when force_chk is set. The expected
  // outcome follows from the image rules alone.
  task automatic load_image(input int n, input bit force_chk, input logic [7:0] chk_val,
                            input logic [7:0] chk_delta, input bit stall, input bit poke);
    logic [7:0] s;
    logic [7:0] b;
    logic [7:0] chk_b;
    pulse_start();
    chk("start_hold", {cpu_hold, busy, byte_ready, error}, 4'b1110);
    if (n < 1 || n > 64) begin
      exp_ev_q.push_back(1'b0);
      send_byte(n[7:0], stall);
      wait_drain("badlen_drain");
      chk("badlen_error", {error, busy, cpu_hold}, 3'b100);
      return;
    end
    send_byte(n[7:0], stall);
    s = 8'd0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[i][8*k +: 8];
        s = s + b;
        if (k == 3) exp_wr_q.push_back({i[5:0], img[i]});
        send_byte(b, stall);
      end
      if (poke && i == 1) begin
        pulse_start();
        chk("poke_busy", {busy, cpu_hold}, 2'b11);
      end
    end
    chk_b = force_chk ? chk_val : 8'(s + chk_delta);
    exp_ev_q.push_back(chk_b == s);
    send_byte(chk_b, stall);
    wait_drain("load_drain");
    chk("end_idle", {busy, cpu_hold, error}, {2'b00, chk_b != s});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [37:0] e;
    if (reset) begin
      if (we) begin
        chk("write_ready_low", byte_ready, 1'b0);
        chk("write_hold", {busy, cpu_hold}, 2'b11);
        if (exp_wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0h:%0h expected=none", waddr, wdata);
        end else begin
          e = exp_wr_q.pop_front();
          chk("write_addr", waddr, e[37:32]);
          chk("write_data", wdata, e[31:0]);
        end
      end
      if (done && error) chk("done_error_excl", {done, error}, 2'b00);
      if (done) begin
        chk("done_idle", {busy, cpu_hold, error}, 3'b000);
        if (exp_ev_q.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
        else chk("done_event", exp_ev_q.pop_front(), 1'b1);
      end
      if (error && !error_q) begin
        chk("error_idle", {busy, cpu_hold}, 2'b00);
        if (exp_ev_q.size() == 0) chk("unexpected_error", 1'b1, 1'b0);
        else chk("error_event", exp_ev_q.pop_front(), 1'b0);
      end
    end
    error_q = error;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    repeat (3) @(negedge clk);
    start = 1'b1;  // start during reset must be ignored
    @(negedge clk);
    chk("rst_ready", byte_ready, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_waddr", waddr, 6'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_hold", cpu_hold, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single nop word
    img[0] = 32'h0000_0013;
    load_image(1, 1'b1, 8'h13, 8'd0, 1'b0, 1'b0);

    // full image
    for (int i = 0; i < 64; i++) img[i] = 32'h0010_0093 + i;
    load_image(64, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

    // bad checksum (correct would be 0x38)
    img[0] = 32'hDEAD_BEEF;
    img[1] = 32'h0000_0000;
    load_image(2, 1'b1, 8'h00, 8'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("error_sticky", error, 1'b1);

    // bad lengths
    load_image(0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    load_image(65, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

    // randomized images with stalls, mid-load start and random checksum errors
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      load_image(n, 1'b0, 8'd0, ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
                 1'b1, n > 2);
    end

    // abort mid-word with asynchronous reset
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    pulse_start();
    send_byte(8'd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) exp_wr_q.push_back({6'd0, img[0]});
      send_byte(img[0][8*k +: 8], 1'b0);
    end
    send_byte(img[1][7:0], 1'b0);
    send_byte(img[1][15:8], 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_outputs", {byte_ready, we, waddr, wdata, cpu_hold, busy, done, error}, 64'd0);
    chk("abort_queues", 64'(exp_wr_q.size() + exp_ev_q.size()), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    load_image(4, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    n = 64;
    for (int i = 0; i < n; i++) img[i] = $urandom;
    load_image(n, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("final_idle", {busy, cpu_hold, done, we}, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
